// File: rtl/ddr4_cmd_sched.sv
// ddr4_cmd_sched: two-requester DDR4 PRE/ACT/CAS scheduler with a per-bank open-row table.
// Optional macro DDR4_OPEN_PAGE_EN keeps rows open (row hits skip ACT); default build uses RDA/WRA.
module ddr4_cmd_sched #(
    parameter int ADDRWIDTH = 17,
    parameter int COLWIDTH  = 10,
    parameter int BGWIDTH   = 2,
    parameter int BAWIDTH   = 2,
    parameter int TRP       = 4,
    parameter int TRCD      = 4,
    parameter int TCL       = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [1:0]               req_valid,
    input  logic [1:0]               req_we,
    input  logic [2*BGWIDTH-1:0]     req_bg,
    input  logic [2*BAWIDTH-1:0]     req_ba,
    input  logic [2*ADDRWIDTH-1:0]   req_row,
    input  logic [2*COLWIDTH-1:0]    req_col,
    output logic [1:0]               req_ready,
    input  logic                     stall,
    output logic                     cs_n,
    output logic                     act_n,
    output logic [ADDRWIDTH-1:0]     A,
    output logic [BGWIDTH-1:0]       bg,
    output logic [BAWIDTH-1:0]       ba,
    output logic [1:0]               done
);
    localparam int BKW   = BGWIDTH + BAWIDTH;
    localparam int NBANK = 1 << BKW;
    localparam int A_AP  = 10;
    localparam logic [3:0] TRP_LAST  = 4'(TRP - 1);
    localparam logic [3:0] TRCD_LAST = 4'(TRCD - 1);
    localparam logic [3:0] TCL_LAST  = 4'(TCL - 1);
`ifdef DDR4_OPEN_PAGE_EN
    localparam logic CAS_AP = 1'b0;
`else
    localparam logic CAS_AP = 1'b1;
`endif

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRE       = 3'd1,
        TRP_WAIT  = 3'd2,
        ACT       = 3'd3,
        TRCD_WAIT = 3'd4,
        CAS       = 3'd5,
        TCL_WAIT  = 3'd6
    } state_t;

    state_t                 state_r, state_s;
    logic [3:0]             cnt_r, cnt_s;
    logic                   ptr_r;
    logic                   owner_r;
    logic                   we_r;
    logic [BGWIDTH-1:0]     tbg_r;
    logic [BAWIDTH-1:0]     tba_r;
    logic [ADDRWIDTH-1:0]   trow_r;
    logic [COLWIDTH-1:0]    tcol_r;
    logic [NBANK-1:0]       open_r;
    logic [ADDRWIDTH-1:0]   open_row_r [NBANK];

    logic                   gnt_idx_s;
    logic                   grant_s;
    logic                   issue_s;
    logic                   done_s;
    logic                   sel_we_s;
    logic [BGWIDTH-1:0]     sel_bg_s;
    logic [BAWIDTH-1:0]     sel_ba_s;
    logic [ADDRWIDTH-1:0]   sel_row_s;
    logic [COLWIDTH-1:0]    sel_col_s;
    logic [BKW-1:0]         sel_bank_s;
    logic [BKW-1:0]         cur_bank_s;
    logic                   sel_hit_s;

    // Round-robin winner and its request fields, plus the row-table lookup for that bank.
    always_comb begin
        gnt_idx_s  = req_valid[ptr_r] ? ptr_r : ~ptr_r;
        sel_we_s   = gnt_idx_s ? req_we[1] : req_we[0];
        sel_bg_s   = gnt_idx_s ? req_bg[2*BGWIDTH-1:BGWIDTH] : req_bg[BGWIDTH-1:0];
        sel_ba_s   = gnt_idx_s ? req_ba[2*BAWIDTH-1:BAWIDTH] : req_ba[BAWIDTH-1:0];
        sel_row_s  = gnt_idx_s ? req_row[2*ADDRWIDTH-1:ADDRWIDTH] : req_row[ADDRWIDTH-1:0];
        sel_col_s  = gnt_idx_s ? req_col[2*COLWIDTH-1:COLWIDTH] : req_col[COLWIDTH-1:0];
        sel_bank_s = {sel_bg_s, sel_ba_s};
        cur_bank_s = {tbg_r, tba_r};
        sel_hit_s  = open_r[sel_bank_s] && (open_row_r[sel_bank_s] == sel_row_s);
    end

    // Next-state logic: command states hold under stall, wait states always count.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        grant_s = 1'b0;
        issue_s = 1'b0;
        done_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (!stall && (req_valid != 2'b00)) begin
                    grant_s = 1'b1;
                    cnt_s   = 4'd0;
                    if (sel_hit_s) begin
                        state_s = CAS;
                    end else if (open_r[sel_bank_s]) begin
                        state_s = PRE;
                    end else begin
                        state_s = ACT;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            PRE, ACT, CAS: begin
                if (!stall) begin
                    issue_s = 1'b1;
                    cnt_s   = 4'd0;
                    if (state_r == PRE) begin
                        state_s = TRP_WAIT;
                    end else if (state_r == ACT) begin
                        state_s = TRCD_WAIT;
                    end else begin
                        state_s = TCL_WAIT;
                    end
                end else begin
                    state_s = state_r;
                end
            end
            TRP_WAIT: begin
                if (cnt_r == TRP_LAST) begin
                    state_s = ACT;
                    cnt_s   = 4'd0;
                end else begin
                    cnt_s = cnt_r + 4'd1;
                end
            end
            TRCD_WAIT: begin
                if (cnt_r == TRCD_LAST) begin
                    state_s = CAS;
                    cnt_s   = 4'd0;
                end else begin
                    cnt_s = cnt_r + 4'd1;
                end
            end
            TCL_WAIT: begin
                if (cnt_r == TCL_LAST) begin
                    state_s = IDLE;
                    cnt_s   = 4'd0;
                    done_s  = 1'b1;
                end else begin
                    cnt_s = cnt_r + 4'd1;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = 4'd0;
            end
        endcase
    end

    // Pin decode; reset forces the deselect/idle values in the same cycle.
    always_comb begin
        req_ready = 2'b00;
        done      = 2'b00;
        cs_n      = 1'b1;
        act_n     = 1'b1;
        A         = '0;
        bg        = tbg_r;
        ba        = tba_r;
        if (reset) begin
            bg = '0;
            ba = '0;
        end else begin
            req_ready = grant_s ? (gnt_idx_s ? 2'b10 : 2'b01) : 2'b00;
            done      = done_s ? (owner_r ? 2'b10 : 2'b01) : 2'b00;
            if (issue_s) begin
                cs_n = 1'b0;
                case (state_r)
                    PRE: begin
                        A[16:14] = 3'b010;
                    end
                    ACT: begin
                        act_n = 1'b0;
                        A     = trow_r;
                    end
                    CAS: begin
                        A[16:14]         = we_r ? 3'b100 : 3'b101;
                        A[COLWIDTH-1:0]  = tcol_r;
                        A[A_AP]          = CAS_AP;
                    end
                    default: begin
                        cs_n = 1'b1;
                    end
                endcase
            end else begin
                cs_n = 1'b1;
            end
        end
    end

    // State, arbitration pointer, latched request and open-row table.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
            ptr_r   <= 1'b0;
            owner_r <= 1'b0;
            we_r    <= 1'b0;
            tbg_r   <= '0;
            tba_r   <= '0;
            trow_r  <= '0;
            tcol_r  <= '0;
            open_r  <= '0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            if (grant_s) begin
                ptr_r   <= ~gnt_idx_s;
                owner_r <= gnt_idx_s;
                we_r    <= sel_we_s;
                tbg_r   <= sel_bg_s;
                tba_r   <= sel_ba_s;
                trow_r  <= sel_row_s;
                tcol_r  <= sel_col_s;
            end
            if (issue_s && (state_r == PRE)) begin
                open_r[cur_bank_s] <= 1'b0;
            end else if (issue_s && (state_r == ACT)) begin
                open_r[cur_bank_s]     <= 1'b1;
                open_row_r[cur_bank_s] <= trow_r;
            end else if (issue_s && (state_r == CAS) && CAS_AP) begin
                open_r[cur_bank_s] <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ddr4_cmd_sched.sv
// Testbench for ddr4_cmd_sched: directed vector table, corner-case sequences and a
// randomized run against a command-schedule reference model.
module tb_ddr4_cmd_sched;
    localparam int AW = 17, CW = 10, BGW = 2, BAW = 2;
    localparam int TRP = 4, TRCD = 4, TCL = 4;
`ifdef DDR4_OPEN_PAGE_EN
    localparam bit OPEN = 1'b1;
`else
    localparam bit OPEN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, stall, cs_n, act_n;
    logic [1:0] req_valid, req_we, req_ready, done;
    logic [2*BGW-1:0] req_bg;
    logic [2*BAW-1:0] req_ba;
    logic [2*AW-1:0] req_row;
    logic [2*CW-1:0] req_col;
    logic [AW-1:0] A;
    logic [BGW-1:0] bg;
    logic [BAW-1:0] ba;

    ddr4_cmd_sched #(.ADDRWIDTH(AW), .COLWIDTH(CW), .BGWIDTH(BGW), .BAWIDTH(BAW),
                     .TRP(TRP), .TRCD(TRCD), .TCL(TCL)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we),
        .req_bg(req_bg), .req_ba(req_ba), .req_row(req_row), .req_col(req_col),
        .req_ready(req_ready), .stall(stall), .cs_n(cs_n), .act_n(act_n),
        .A(A), .bg(bg), .ba(ba), .done(done));

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, got, exp);
        end
    endtask

    function automatic logic [AW-1:0] a_pre();
        logic [AW-1:0] a;
        a = '0;
        a[16:14] = 3'b010;
        return a;
    endfunction

    function automatic logic [AW-1:0] a_cas(input logic we, input logic [CW-1:0] col);
        logic [AW-1:0] a;
        a = '0;
        a[16:14] = we ? 3'b100 : 3'b101;
        a[CW-1:0] = col;
        a[10] = !OPEN;
        return a;
    endfunction

    // ---------------- reference model: queue of pending commands with minimum gaps
    typedef enum {M_PRE, M_ACT, M_CAS} mcmd_t;
    typedef struct { mcmd_t kind; int gap; } mstep_t;
    mstep_t m_q[$];
    int m_last, m_done_at, m_free_at;
    bit m_ptr, m_owner, m_we;
    logic [BGW-1:0] m_bg;
    logic [BAW-1:0] m_ba;
    logic [AW-1:0] m_row;
    logic [CW-1:0] m_col;
    bit m_open [16];
    logic [AW-1:0] m_open_row [16];

    task automatic push_step(input mcmd_t k, input int gap);
        mstep_t s;
        s.kind = k;
        s.gap = gap;
        m_q.push_back(s);
    endtask

    task automatic model_cycle();
        logic [1:0] e_ready, e_done;
        logic e_cs, e_act;
        logic [AW-1:0] e_a;
        logic [BGW-1:0] e_bg;
        logic [BAW-1:0] e_ba;
        int bk, w;
        mstep_t s;
        e_ready = 2'b00; e_done = 2'b00; e_cs = 1'b1; e_act = 1'b1; e_a = '0;
        e_bg = m_bg; e_ba = m_ba;
        if (reset) begin
            e_bg = '0; e_ba = '0;
            m_q.delete();
            m_ptr = 1'b0; m_done_at = -1; m_free_at = 0; m_last = 0;
            m_bg = '0; m_ba = '0; m_row = '0; m_col = '0; m_we = 1'b0; m_owner = 1'b0;
            for (int i = 0; i < 16; i++) m_open[i] = 1'b0;
        end else begin
            bk = int'({m_bg, m_ba});
            if (m_q.size() > 0 && !stall && cyc >= m_last + m_q[0].gap) begin
                s = m_q.pop_front();
                m_last = cyc;
                e_cs = 1'b0;
                case (s.kind)
                    M_PRE: begin e_a = a_pre(); m_open[bk] = 1'b0; end
                    M_ACT: begin e_act = 1'b0; e_a = m_row; m_open[bk] = 1'b1; m_open_row[bk] = m_row; end
                    default: begin
                        e_a = a_cas(m_we, m_col);
                        if (!OPEN) m_open[bk] = 1'b0;
                        m_done_at = cyc + TCL;
                        m_free_at = cyc + TCL + 1;
                    end
                endcase
            end
            if (cyc == m_done_at) e_done = m_owner ? 2'b10 : 2'b01;
            if (m_q.size() == 0 && cyc >= m_free_at && !stall && req_valid != 2'b00) begin
                w = req_valid[m_ptr] ? int'(m_ptr) : int'(!m_ptr);
                e_ready = (w == 1) ? 2'b10 : 2'b01;
                m_ptr = (w == 0);
                m_owner = (w == 1);
                m_we = req_we[w];
                m_bg = req_bg[w*BGW +: BGW];
                m_ba = req_ba[w*BAW +: BAW];
                m_row = req_row[w*AW +: AW];
                m_col = req_col[w*CW +: CW];
                bk = int'({m_bg, m_ba});
                m_last = cyc;
                if (m_open[bk] && m_open_row[bk] == m_row) begin
                    push_step(M_CAS, 1);
                end else if (m_open[bk]) begin
                    push_step(M_PRE, 1); push_step(M_ACT, TRP + 1); push_step(M_CAS, TRCD + 1);
                end else begin
                    push_step(M_ACT, 1); push_step(M_CAS, TRCD + 1);
                end
            end
        end
        check("m_ready", 32'(req_ready), 32'(e_ready));
        check("m_cs_n", 32'(cs_n), 32'(e_cs));
        check("m_act_n", 32'(act_n), 32'(e_act));
        check("m_A", 32'(A), 32'(e_a));
        check("m_bg", 32'(bg), 32'(e_bg));
        check("m_ba", 32'(ba), 32'(e_ba));
        check("m_done", 32'(done), 32'(e_done));
    endtask

    int gq[$], dq[$];

    task automatic sample();
        @(negedge clk);
        model_cycle();
        if (req_ready[0]) gq.push_back(0);
        if (req_ready[1]) gq.push_back(1);
        if (done[0]) dq.push_back(0);
        if (done[1]) dq.push_back(1);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic tick();
        sample();
        adv();
    endtask

    task automatic clear_in();
        req_valid = 2'b00; req_we = 2'b00; req_bg = '0; req_ba = '0; req_row = '0; req_col = '0;
        stall = 1'b0;
    endtask

    task automatic set_req(input int i, input logic we, input logic [BGW-1:0] b, input logic [BAW-1:0] a,
                           input logic [AW-1:0] row, input logic [CW-1:0] col);
        req_we[i] = we;
        req_bg[i*BGW +: BGW] = b;
        req_ba[i*BAW +: BAW] = a;
        req_row[i*AW +: AW] = row;
        req_col[i*CW +: CW] = col;
    endtask

    // ---------------- directed vector table
    typedef struct {
        logic rst; logic stall; logic [1:0] valid; logic we;
        logic [BGW-1:0] bgv; logic [BAW-1:0] bav; logic [AW-1:0] row; logic [CW-1:0] col;
        logic [1:0] e_ready; logic e_cs; logic e_act; logic [AW-1:0] e_a; logic [1:0] e_done;
    } vec_t;
    vec_t vecs[$];
    localparam int K_HIT = 0, K_CLOSED = 1, K_CONFLICT = 2;

    task automatic add_desel(inout vec_t v, input int n);
        v.e_ready = 2'b00; v.e_cs = 1'b1; v.e_act = 1'b1; v.e_a = '0; v.e_done = 2'b00;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    task automatic add_txn(input int kind, input logic we, input logic [BGW-1:0] b, input logic [BAW-1:0] a,
                           input logic [AW-1:0] row, input logic [CW-1:0] col);
        vec_t v;
        v = '{default: '0};
        v.valid = 2'b01; v.we = we; v.bgv = b; v.bav = a; v.row = row; v.col = col;
        v.e_ready = 2'b01; v.e_cs = 1'b1; v.e_act = 1'b1;
        vecs.push_back(v);
        v.valid = 2'b00;
        if (kind == K_CONFLICT) begin
            add_desel(v, 0); v.e_cs = 1'b0; v.e_a = a_pre(); vecs.push_back(v);
            add_desel(v, TRP);
        end
        if (kind != K_HIT) begin
            add_desel(v, 0); v.e_cs = 1'b0; v.e_act = 1'b0; v.e_a = row; vecs.push_back(v);
            add_desel(v, TRCD);
        end
        add_desel(v, 0); v.e_cs = 1'b0; v.e_a = a_cas(we, col); vecs.push_back(v);
        add_desel(v, TCL - 1);
        v.e_done = 2'b01; vecs.push_back(v);
    endtask

    logic [AW-1:0] rows_pool [3];

    initial begin
        vec_t v;
        reset = 1'b1;
        clear_in();
        rows_pool[0] = 17'h001A5; rows_pool[1] = 17'h001A6; rows_pool[2] = 17'h0000F;

        v = '{default: '0};
        v.rst = 1'b1;
        add_desel(v, 2);
        add_txn(K_CLOSED, 1'b0, 2'd1, 2'd2, 17'h001A5, 10'h040);
        v = '{default: '0};
        add_desel(v, 1);
        add_txn(OPEN ? K_HIT : K_CLOSED, 1'b0, 2'd1, 2'd2, 17'h001A5, 10'h041);
        add_txn(OPEN ? K_CONFLICT : K_CLOSED, 1'b1, 2'd1, 2'd2, 17'h001A6, 10'h3FF);
        add_txn(K_CLOSED, 1'b1, 2'd0, 2'd0, 17'h1FFFF, 10'h000);
        add_desel(v, 2);

        @(posedge clk);
        #1;
        foreach (vecs[i]) begin
            reset = vecs[i].rst;
            stall = vecs[i].stall;
            req_valid = vecs[i].valid;
            set_req(0, vecs[i].we, vecs[i].bgv, vecs[i].bav, vecs[i].row, vecs[i].col);
            sample();
            check("tbl_ready", 32'(req_ready), 32'(vecs[i].e_ready));
            check("tbl_cs_n", 32'(cs_n), 32'(vecs[i].e_cs));
            check("tbl_act_n", 32'(act_n), 32'(vecs[i].e_act));
            check("tbl_A", 32'(A), 32'(vecs[i].e_a));
            check("tbl_done", 32'(done), 32'(vecs[i].e_done));
            adv();
        end

        // Both requesters held valid: grants and completions alternate 0,1,0,1.
        clear_in(); reset = 1'b1; tick(); reset = 1'b0;
        gq.delete(); dq.delete();
        req_valid = 2'b11;
        set_req(0, 1'b0, 2'd0, 2'd0, 17'h00010, 10'h001);
        set_req(1, 1'b1, 2'd1, 2'd1, 17'h00020, 10'h002);
        for (int i = 0; i < 50; i++) tick();
        check("alt_grants", 32'(gq.size() >= 4), 32'd1);
        check("alt_dones", 32'(dq.size() >= 4), 32'd1);
        for (int i = 0; i < 4; i++) begin
            if (i < gq.size()) check("alt_grant_order", 32'(gq[i]), 32'(i % 2));
            if (i < dq.size()) check("alt_done_order", 32'(dq[i]), 32'(i % 2));
        end

        // Stall across TRCD_WAIT and into CAS: nothing issues until stall drops.
        clear_in(); reset = 1'b1; tick(); reset = 1'b0;
        req_valid = 2'b01;
        set_req(0, 1'b0, 2'd2, 2'd3, 17'h00ABC, 10'h155);
        sample(); check("stall_grant", 32'(req_ready), 32'd1); adv();
        req_valid = 2'b00;
        sample(); check("stall_act", 32'(act_n), 32'd0); adv();
        stall = 1'b1;
        for (int i = 0; i < 10; i++) begin
            sample(); check("stall_cs_n", 32'(cs_n), 32'd1); adv();
        end
        stall = 1'b0;
        sample();
        check("stall_cas_cs", 32'(cs_n), 32'd0);
        check("stall_cas_A", 32'(A), 32'(a_cas(1'b0, 10'h155)));
        adv();
        for (int i = 0; i < TCL + 1; i++) tick();

        // Reset during TCL_WAIT: command dropped, table cleared, same row re-activated.
        clear_in(); reset = 1'b1; tick(); reset = 1'b0;
        req_valid = 2'b01;
        set_req(0, 1'b0, 2'd0, 2'd1, 17'h00055, 10'h00A);
        tick();
        req_valid = 2'b00;
        for (int i = 0; i < TRCD + 2 + 1; i++) tick();
        reset = 1'b1; tick(); reset = 1'b0;
        for (int i = 0; i < TCL + 2; i++) begin
            sample();
            check("rst_done", 32'(done), 32'd0);
            check("rst_cs_n", 32'(cs_n), 32'd1);
            adv();
        end
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        sample(); check("rst_reopen_act", 32'(act_n), 32'd0); check("rst_reopen_A", 32'(A), 32'h55); adv();
        for (int i = 0; i < TRCD + TCL + 2; i++) tick();

        // Randomized traffic against the reference model.
        clear_in(); reset = 1'b1; tick(); reset = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 299) == 0);
            stall = ($urandom_range(0, 4) == 0);
            for (int i = 0; i < 2; i++) begin
                req_valid[i] = ($urandom_range(0, 2) != 0);
                set_req(i, 1'($urandom_range(0, 1)), BGW'($urandom_range(0, 1)), BAW'($urandom_range(0, 1)),
                        rows_pool[$urandom_range(0, 2)], CW'($urandom_range(0, 1023)));
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
